// File: rtl/key_pkg.sv
// key_pkg: shared states, key codes and digit limit for the keypad entry block.
package key_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ENTRY  = 2'b01,
        ST_COMMIT = 2'b10
    } state_t;

    localparam logic [3:0] KEY_STAR   = 4'hE;
    localparam logic [3:0] KEY_HASH   = 4'hF;
    localparam logic [2:0] MAX_DIGITS = 3'd4;

    function automatic logic [3:0] thermo(input logic [2:0] n);
        return 4'((5'd1 << n) - 5'd1);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD digit to active-high 7-segment glyph, segment a on bit 0; non-digits blank.
module seg7_decode
    import key_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    always_comb begin
        case (i_digit)
            4'h0: o_seg = 7'h3F;
            4'h1: o_seg = 7'h06;
            4'h2: o_seg = 7'h5B;
            4'h3: o_seg = 7'h4F;
            4'h4: o_seg = 7'h66;
            4'h5: o_seg = 7'h6D;
            4'h6: o_seg = 7'h7D;
            4'h7: o_seg = 7'h07;
            4'h8: o_seg = 7'h7F;
            4'h9: o_seg = 7'h6F;
            default: o_seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/key_entry.sv
// key_entry: keypad code entry (up to 4 BCD digits, '*' clears, '#' commits) with registered display/status.
// Optional inactivity timeout in ENTRY enabled by defining KEY_ENTRY_TIMEOUT_EN.
module key_entry
    import key_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        code_ready,
    output logic        code_valid,
    output logic [15:0] code_value,
    output logic [6:0]  S,
    output logic [7:0]  LEDs
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_t      r_state;
    logic [15:0] r_buf;
    logic [2:0]  r_cnt;
    logic        r_code_valid;
    logic [15:0] r_code_value;
    logic [6:0]  r_seg;
    logic [7:0]  r_leds;

    state_t      w_state;
    logic [15:0] w_buf;
    logic [2:0]  w_cnt;
    logic [6:0]  w_glyph;
    logic [6:0]  w_seg;
    logic        w_key, w_digit, w_dig_ok, w_dig_ovf, w_star, w_hash, w_ack, w_tmo, w_clear;
    logic        w_ovf, w_to;

    seg7_decode u_seg (
        .i_digit (key_code),
        .o_seg   (w_glyph)
    );

    // Keys are dead in COMMIT, so a key coinciding with code_ready is dropped too.
    always_comb begin
        w_key     = key_valid && r_state != ST_COMMIT;
        w_digit   = key_code <= 4'h9;
        w_dig_ok  = w_key && w_digit && r_cnt != MAX_DIGITS;
        w_dig_ovf = w_key && w_digit && r_cnt == MAX_DIGITS;
        w_star    = w_key && key_code == KEY_STAR;
        w_hash    = w_key && key_code == KEY_HASH && r_state == ST_ENTRY;
        w_ack     = r_state == ST_COMMIT && code_ready;
    end

`ifdef KEY_ENTRY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] r_tcnt;

    // A key acted on in the same cycle takes priority over an expiring timeout.
    assign w_tmo = r_state == ST_ENTRY && r_tcnt == TMAX && !(w_dig_ok || w_star || w_hash);
    assign w_to  = !w_star && (r_leds[6] || w_tmo);

    always_ff @(posedge clk) begin
        if (!rst_n || w_state != ST_ENTRY || w_dig_ok)
            r_tcnt <= '0;
        else
            r_tcnt <= r_tcnt + 1'b1;
    end
`else
    assign w_tmo = 1'b0;
    assign w_to  = 1'b0;
`endif

    always_comb begin
        w_clear = w_star || w_ack || w_tmo;
        w_state = w_clear ? ST_IDLE : w_hash ? ST_COMMIT : w_dig_ok ? ST_ENTRY : r_state;
        w_buf   = w_clear ? 16'h0 : w_dig_ok ? {r_buf[11:0], key_code} : r_buf;
        w_cnt   = w_clear ? 3'd0 : w_dig_ok ? r_cnt + 3'd1 : r_cnt;
        w_ovf   = !w_star && (r_leds[7] || w_dig_ovf);
        w_seg   = w_state == ST_IDLE ? 7'h00 : w_dig_ok ? w_glyph : r_seg;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_buf        <= '0;
            r_cnt        <= '0;
            r_code_valid <= 1'b0;
            r_code_value <= '0;
            r_seg        <= '0;
            r_leds       <= '0;
        end else begin
            r_state      <= w_state;
            r_buf        <= w_buf;
            r_cnt        <= w_cnt;
            r_code_valid <= w_hash ? 1'b1 : w_ack ? 1'b0 : r_code_valid;
            r_code_value <= w_hash ? r_buf : r_code_value;
            r_seg        <= w_seg;
            r_leds       <= {w_ovf, w_to, w_state, thermo(w_cnt)};
        end
    end

    assign code_valid = r_code_valid;
    assign code_value = r_code_value;
    assign S          = r_seg;
    assign LEDs       = r_leds;

endmodule

// File: tb/tb_key_entry.sv
// tb_key_entry: scoreboard bench for key_entry; expected outputs queued per driven cycle.
module tb_key_entry;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        code_ready = 1'b0;
    logic        code_valid;
    logic [15:0] code_value;
    logic [6:0]  S;
    logic [7:0]  LEDs;

    typedef struct packed {
        logic        cv;
        logic [15:0] val;
        logic [6:0]  s;
        logic [7:0]  leds;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    localparam logic [6:0] G1 = 7'h06, G2 = 7'h5B, G3 = 7'h4F, G4 = 7'h66, G6 = 7'h7D, G9 = 7'h6F;

    key_entry #(.TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .code_ready (code_ready),
        .code_valid (code_valid),
        .code_value (code_value),
        .S          (S),
        .LEDs       (LEDs)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, expv);
        end
    endtask

    function automatic exp_t ex(input logic cv, input logic [15:0] val, input logic [6:0] s, input logic [7:0] leds);
        exp_t e;
        e.cv = cv;
        e.val = val;
        e.s = s;
        e.leds = leds;
        return e;
    endfunction

    // Drive one cycle of inputs, queue what must appear after the edge, then compare.
    task automatic step(input logic kv, input logic [3:0] kc, input logic cr, input exp_t e, input string tag);
        exp_t  got;
        string t;
        key_valid = kv;
        key_code = kc;
        code_ready = cr;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        code_ready = 1'b0;
        if (sb_q.size() == 0) begin
            check({tag, " queue"}, 32'd0, 32'd1);
        end else begin
            got = sb_q.pop_front();
            t = tag_q.pop_front();
            check({t, " code_valid"}, 32'(code_valid), 32'(got.cv));
            check({t, " code_value"}, 32'(code_value), 32'(got.val));
            check({t, " S"}, 32'(S), 32'(got.s));
            check({t, " LEDs"}, 32'(LEDs), 32'(got.leds));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        step(1'b0, 4'h0, 1'b0, ex(0, 16'h0, 0, 8'h00), "reset");
        step(1'b1, 4'h5, 1'b1, ex(0, 16'h0, 0, 8'h00), "reset_keys");
        rst_n = 1'b1;

        // 1,2,3,'#' with code_ready held
        step(1'b1, 4'h1, 1'b1, ex(0, 16'h0, G1, 8'h11), "k1");
        step(1'b1, 4'h2, 1'b1, ex(0, 16'h0, G2, 8'h13), "k2");
        step(1'b1, 4'h3, 1'b1, ex(0, 16'h0, G3, 8'h17), "k3");
        step(1'b1, 4'hF, 1'b1, ex(1, 16'h0123, G3, 8'h27), "hash_0123");
        step(1'b0, 4'h0, 1'b1, ex(0, 16'h0123, 0, 8'h00), "ack_0123");
        step(1'b0, 4'h0, 1'b1, ex(0, 16'h0123, 0, 8'h00), "idle_after_ack");

        // overflow: 9,8,7,6,5 then '#'
        step(1'b1, 4'h9, 1'b0, ex(0, 16'h0123, G9, 8'h11), "k9");
        step(1'b1, 4'h8, 1'b0, ex(0, 16'h0123, 7'h7F, 8'h13), "k8");
        step(1'b1, 4'h7, 1'b0, ex(0, 16'h0123, 7'h07, 8'h17), "k7");
        step(1'b1, 4'h6, 1'b0, ex(0, 16'h0123, G6, 8'h1F), "k6");
        step(1'b1, 4'h5, 1'b0, ex(0, 16'h0123, G6, 8'h9F), "k5_ovf");
        step(1'b1, 4'hB, 1'b0, ex(0, 16'h0123, G6, 8'h9F), "letter_entry");
        step(1'b1, 4'hF, 1'b0, ex(1, 16'h9876, G6, 8'hAF), "hash_9876");
        step(1'b0, 4'h0, 1'b1, ex(0, 16'h9876, 0, 8'h80), "ack_9876");
        step(1'b1, 4'hE, 1'b0, ex(0, 16'h9876, 0, 8'h00), "star_idle");

        // 4,'*','#'
        step(1'b1, 4'h4, 1'b0, ex(0, 16'h9876, G4, 8'h11), "k4");
        step(1'b1, 4'hE, 1'b0, ex(0, 16'h9876, 0, 8'h00), "star_clear");
        step(1'b1, 4'hF, 1'b0, ex(0, 16'h9876, 0, 8'h00), "hash_idle");
        step(1'b0, 4'h0, 1'b1, ex(0, 16'h9876, 0, 8'h00), "ready_idle");

        // COMMIT hold with ignored keys, then key coincident with code_ready
        step(1'b1, 4'h1, 1'b0, ex(0, 16'h9876, G1, 8'h11), "c1");
        step(1'b1, 4'h2, 1'b0, ex(0, 16'h9876, G2, 8'h13), "c2");
        step(1'b1, 4'hF, 1'b0, ex(1, 16'h0012, G2, 8'h23), "hash_0012");
        for (int i = 0; i < 10; i++)
            step(i == 4 || i == 7, i == 7 ? 4'hE : 4'h5, 1'b0, ex(1, 16'h0012, G2, 8'h23), "commit_hold");
        step(1'b1, 4'h7, 1'b1, ex(0, 16'h0012, 0, 8'h00), "key_with_ack");
        step(1'b0, 4'h0, 1'b0, ex(0, 16'h0012, 0, 8'h00), "idle_after_drop");

        // reset mid-COMMIT
        step(1'b1, 4'h3, 1'b0, ex(0, 16'h0012, G3, 8'h11), "r3");
        step(1'b1, 4'hF, 1'b0, ex(1, 16'h0003, G3, 8'h21), "hash_0003");
        rst_n = 1'b0;
        step(1'b0, 4'h0, 1'b0, ex(0, 16'h0, 0, 8'h00), "reset_commit");
        rst_n = 1'b1;
        step(1'b0, 4'h0, 1'b1, ex(0, 16'h0, 0, 8'h00), "after_reset");

        // inactivity timeout (TIMEOUT_CYCLES = 8)
        step(1'b1, 4'h2, 1'b0, ex(0, 16'h0, G2, 8'h11), "t2");
        for (int i = 0; i < 7; i++)
            step(1'b0, 4'h0, 1'b0, ex(0, 16'h0, G2, 8'h11), "t_wait");
`ifdef KEY_ENTRY_TIMEOUT_EN
        step(1'b0, 4'h0, 1'b0, ex(0, 16'h0, 0, 8'h40), "t_expire");
        step(1'b1, 4'h4, 1'b0, ex(0, 16'h0, G4, 8'h51), "t_new_key");
        step(1'b1, 4'hE, 1'b0, ex(0, 16'h0, 0, 8'h00), "t_star");
`else
        step(1'b0, 4'h0, 1'b0, ex(0, 16'h0, G2, 8'h11), "t_stay");
        for (int i = 0; i < 8; i++)
            step(1'b0, 4'h0, 1'b0, ex(0, 16'h0, G2, 8'h11), "t_stay_long");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
